noc_rr_xbar: RTL and testbench
==============================

// Module: noc_rr_xbar
// PURPOSE
//   Parametrised CPU_NB x CPU_NB crossbar NoC replacing the fixed 64-bit noc.
//   Each CPU port sends words over a rdy/vld channel. A destination field inside each word routes it.
//   Each input has an input FIFO; each output has a round-robin arbiter and an output FIFO.
//   Sits between the gen_cpu instances (cpu or cpu_multisim_server) in top.
// PARAMETERS
//   CPU_NB     4   number of CPU ports (>=2)
//   DATA_W     64  word width; dest field = data[DATA_W-1 -: DEST_W], DEST_W=$clog2(CPU_NB) (localparam)
//   IN_DEPTH   2   input FIFO entries per port (>=2, power of 2)
//   OUT_DEPTH  4   output FIFO entries per port (>=2, power of 2)
// PORTS
//   clk                  in   1              clock, all logic on posedge
//   rst                  in   1              asynchronous, active-high reset
//   data_cpu_to_noc_rdy  out  [CPU_NB]       per-port ready, cpu->noc
//   data_cpu_to_noc_vld  in   [CPU_NB]       per-port valid, cpu->noc
//   data_cpu_to_noc      in   [CPU_NB][DATA_W] per-port word, cpu->noc
//   data_noc_to_cpu_rdy  in   [CPU_NB]       per-port ready, noc->cpu
//   data_noc_to_cpu_vld  out  [CPU_NB]       per-port valid, noc->cpu
//   data_noc_to_cpu      out  [CPU_NB][DATA_W] per-port word, noc->cpu
//   drop_cnt             out  32             STATS only: words dropped for bad dest
//   rx_cnt               out  [CPU_NB][32]   STATS only: words delivered per output
// BEHAVIOUR
//   Reset (async assert, sync deassert by caller): all FIFOs empty.
//     Outputs: cpu_to_noc_rdy=1, noc_to_cpu_vld=0, noc_to_cpu=0.
//     Arbiter pointers = CPU_NB-1, so input 0 wins first. Counters=0.
//   Reset mid-operation discards all in-flight words; no partial state survives.
//   Handshake: transfer when vld&&rdy on a posedge.
//     Producer holds vld/data until accepted.
//     Rdy is registered: rdy[i] = (in_count[i] < IN_DEPTH); it is never a function of vld.
//   Input FIFO i: push on handshake; head requests output dest(head).
//   Arbiter, one per output j: candidates are inputs whose non-empty head has dest==j.
//     Grant only if out_count[j] < OUT_DEPTH, using the registered count.
//     No same-cycle pass-through when an output pop makes room.
//     Pick the first candidate searching from ptr[j]+1 upward, wrapping at CPU_NB.
//     On grant: pop input, push output FIFO, ptr[j] := granted index. No grant: ptr holds.
//   Each input requests exactly one output, so grants never conflict.
//     Throughput is one word per input and one per output per cycle.
//   Bad dest (dest >= CPU_NB, possible when CPU_NB is not a power of 2):
//     The head is popped without arbitration in its first cycle at head and silently dropped.
//     drop_cnt increments.
//   Output: vld[j] = out FIFO not empty, data = head (registered FIFO read, no comb path from inputs).
//     Pop on vld&&rdy.
//   Latency: word accepted on edge N lands in output FIFO on edge N+1, so vld is high after N+1.
//     Minimum latency is 2 cycles.
//   Full input FIFO: rdy=0 next cycle. A simultaneous pop does not raise rdy in the same cycle.
//     The registered count rules.
//   FIFO pointers wrap modulo depth. Count has one extra bit to distinguish full from empty.
//   Payload is forwarded unmodified, dest bits included. Per input->output pair, words stay in order.
// CONFIGURATION
//   NOC_STATS_EN defined: drop_cnt and rx_cnt ports exist.
//     32-bit counters wrap at 2^32-1 -> 0. rx_cnt[j] increments on each output j handshake.
//   Undefined: ports and counters absent. Bad-dest words are still dropped.
// TESTING
//   1. Reset, no traffic -> all rdy=1, all vld=0, data=0.
//   2. Single word from cpu0, dest=2, payload 0x8000_0000_0000_00AB (CPU_NB=4)
//      -> out2 vld 2 cycles after handshake, data identical; other outputs idle.
//   3. Inputs 0,1,3 each stream 8 words to dest 2, rdy2=1 -> output 2 order is 0,1,3,0,1,3...
//      One word per cycle, 24 total, per-source order preserved.
//   4. Hold rdy2=0, cpu0 streams to dest 2 -> 4 words in out FIFO, 2 in in FIFO.
//      Then rdy0 drops. Release rdy2 -> all 6 delivered in order, rdy0 returns.
//   5. CPU_NB=3, word with dest=3 -> never delivered, drop_cnt=1 (STATS), other traffic unaffected.
//   6. Assert rst while test 4 is backlogged -> vld=0 and rdy=1 immediately.
//      After release, a new word dest=1 is delivered alone.

Source files
------------

// File: rtl/noc_rr_xbar_if.sv
// Handshake bundle between the CPU ports and noc_rr_xbar.
// master = CPU side, slave = crossbar side.
interface noc_rr_xbar_if #(
    parameter int unsigned CPU_NB = 4,
    parameter int unsigned DATA_W = 64
);
    logic [CPU_NB-1:0]             data_cpu_to_noc_rdy;
    logic [CPU_NB-1:0]             data_cpu_to_noc_vld;
    logic [CPU_NB-1:0][DATA_W-1:0] data_cpu_to_noc;
    logic [CPU_NB-1:0]             data_noc_to_cpu_rdy;
    logic [CPU_NB-1:0]             data_noc_to_cpu_vld;
    logic [CPU_NB-1:0][DATA_W-1:0] data_noc_to_cpu;

    modport master (
        input  data_cpu_to_noc_rdy,
        output data_cpu_to_noc_vld,
        output data_cpu_to_noc,
        output data_noc_to_cpu_rdy,
        input  data_noc_to_cpu_vld,
        input  data_noc_to_cpu
    );

    modport slave (
        output data_cpu_to_noc_rdy,
        input  data_cpu_to_noc_vld,
        input  data_cpu_to_noc,
        input  data_noc_to_cpu_rdy,
        output data_noc_to_cpu_vld,
        output data_noc_to_cpu
    );
endinterface

// File: rtl/noc_rr_xbar.sv
// CPU_NB x CPU_NB crossbar: input FIFOs, per-output round-robin arbiters, output FIFOs.
// Define NOC_STATS_EN to add the drop_cnt / rx_cnt statistics ports.
module noc_rr_xbar #(
    parameter int unsigned CPU_NB    = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned IN_DEPTH  = 2,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    noc_rr_xbar_if.slave      bus
`ifdef NOC_STATS_EN
    ,
    output logic [31:0]             drop_cnt,
    output logic [CPU_NB-1:0][31:0] rx_cnt
`endif
);
    localparam int unsigned DEST_W = $clog2(CPU_NB);
    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned IN_CW  = IN_AW + 1;
    localparam int unsigned OUT_CW = OUT_AW + 1;
    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);

    logic [DATA_W-1:0] in_mem  [CPU_NB][IN_DEPTH];
    logic [IN_AW-1:0]  in_wp   [CPU_NB];
    logic [IN_AW-1:0]  in_rp   [CPU_NB];
    logic [IN_CW-1:0]  in_cnt  [CPU_NB];

    logic [DATA_W-1:0] out_mem [CPU_NB][OUT_DEPTH];
    logic [OUT_AW-1:0] out_wp  [CPU_NB];
    logic [OUT_AW-1:0] out_rp  [CPU_NB];
    logic [OUT_CW-1:0] out_cnt [CPU_NB];

    logic [DEST_W-1:0] ptr       [CPU_NB];
    logic [DEST_W-1:0] grant_idx [CPU_NB];
    logic [DATA_W-1:0] in_head   [CPU_NB];
    logic [DEST_W-1:0] in_dest   [CPU_NB];

    logic [CPU_NB-1:0] in_ne;
    logic [CPU_NB-1:0] in_rdy;
    logic [CPU_NB-1:0] in_push;
    logic [CPU_NB-1:0] in_pop;
    logic [CPU_NB-1:0] in_drop;
    logic [CPU_NB-1:0] out_ne;
    logic [CPU_NB-1:0] out_push;
    logic [CPU_NB-1:0] out_pop;

    // Input side: head decode, ready from the registered count only.
    always_comb begin
        for (int unsigned i = 0; i < CPU_NB; i++) begin
            in_ne[i]   = (in_cnt[i] != '0);
            in_rdy[i]  = (in_cnt[i] < IN_FULL);
            in_head[i] = in_mem[i][in_rp[i]];
            in_dest[i] = in_head[i][DATA_W-1 -: DEST_W];
            in_drop[i] = in_ne[i] && (32'(in_dest[i]) >= CPU_NB);
            in_push[i] = bus.data_cpu_to_noc_vld[i] && in_rdy[i];
        end
        bus.data_cpu_to_noc_rdy = in_rdy;
    end

    // Output side: registered FIFO head drives the port directly.
    always_comb begin
        for (int unsigned j = 0; j < CPU_NB; j++) begin
            out_ne[j]                  = (out_cnt[j] != '0);
            out_pop[j]                 = out_ne[j] && bus.data_noc_to_cpu_rdy[j];
            bus.data_noc_to_cpu_vld[j] = out_ne[j];
            bus.data_noc_to_cpu[j]     = out_mem[j][out_rp[j]];
        end
    end

    // Each input requests a single output, so per-output arbiters never
    // contend for the same input pop; bad-dest heads are popped unarbitrated.
    always_comb begin
        logic              found;
        logic [DEST_W-1:0] idx;
        found    = 1'b0;
        idx      = '0;
        in_pop   = in_drop;
        out_push = '0;
        for (int unsigned j = 0; j < CPU_NB; j++) begin
            grant_idx[j] = ptr[j];
        end
        for (int unsigned j = 0; j < CPU_NB; j++) begin
            found = 1'b0;
            if (out_cnt[j] < OUT_FULL) begin
                for (int unsigned k = 1; k <= CPU_NB; k++) begin
                    idx = DEST_W'((32'(ptr[j]) + k) % CPU_NB);
                    if (!found && in_ne[idx] && (32'(in_dest[idx]) == j)) begin
                        found        = 1'b1;
                        grant_idx[j] = idx;
                        out_push[j]  = 1'b1;
                        in_pop[idx]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CPU_NB; i++) begin
                in_wp[i]   <= '0;
                in_rp[i]   <= '0;
                in_cnt[i]  <= '0;
                out_wp[i]  <= '0;
                out_rp[i]  <= '0;
                out_cnt[i] <= '0;
                ptr[i]     <= DEST_W'(CPU_NB - 1);
                for (int unsigned d = 0; d < IN_DEPTH; d++) begin
                    in_mem[i][d] <= '0;
                end
                for (int unsigned d = 0; d < OUT_DEPTH; d++) begin
                    out_mem[i][d] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < CPU_NB; i++) begin
                if (in_push[i]) begin
                    in_mem[i][in_wp[i]] <= bus.data_cpu_to_noc[i];
                    in_wp[i]            <= in_wp[i] + 1'b1;
                end
                if (in_pop[i]) begin
                    in_rp[i] <= in_rp[i] + 1'b1;
                end
                in_cnt[i] <= in_cnt[i] + IN_CW'(in_push[i]) - IN_CW'(in_pop[i]);
            end
            for (int unsigned j = 0; j < CPU_NB; j++) begin
                if (out_push[j]) begin
                    out_mem[j][out_wp[j]] <= in_head[grant_idx[j]];
                    out_wp[j]             <= out_wp[j] + 1'b1;
                    ptr[j]                <= grant_idx[j];
                end
                if (out_pop[j]) begin
                    out_rp[j] <= out_rp[j] + 1'b1;
                end
                out_cnt[j] <= out_cnt[j] + OUT_CW'(out_push[j]) - OUT_CW'(out_pop[j]);
            end
        end
    end

`ifdef NOC_STATS_EN
    logic [31:0] drop_add;

    always_comb begin
        drop_add = '0;
        for (int unsigned i = 0; i < CPU_NB; i++) begin
            drop_add = drop_add + 32'(in_drop[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            rx_cnt   <= '0;
        end else begin
            drop_cnt <= drop_cnt + drop_add;
            for (int unsigned j = 0; j < CPU_NB; j++) begin
                rx_cnt[j] <= rx_cnt[j] + 32'(out_pop[j]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_rr_xbar.sv
// Directed bench for noc_rr_xbar: a 4-port instance for routing, arbitration,
// back-pressure and reset, plus a 3-port instance for bad-dest dropping.
module tb_noc_rr_xbar;
    logic clk;
    logic rst;

    noc_rr_xbar_if #(.CPU_NB(4), .DATA_W(64)) bus4 ();
    noc_rr_xbar_if #(.CPU_NB(3), .DATA_W(64)) bus3 ();

`ifdef NOC_STATS_EN
    logic [31:0]      drop4;
    logic [31:0]      drop3;
    logic [3:0][31:0] rx4;
    logic [2:0][31:0] rx3;
`endif

    noc_rr_xbar #(.CPU_NB(4), .DATA_W(64), .IN_DEPTH(2), .OUT_DEPTH(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus4)
`ifdef NOC_STATS_EN
        ,
        .drop_cnt (drop4),
        .rx_cnt   (rx4)
`endif
    );

    noc_rr_xbar #(.CPU_NB(3), .DATA_W(64), .IN_DEPTH(2), .OUT_DEPTH(4)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus3)
`ifdef NOC_STATS_EN
        ,
        .drop_cnt (drop3),
        .rx_cnt   (rx3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dest in the top two bits, source and sequence number in the low bytes
    function automatic logic [63:0] mkword(input int dest, input int src, input int seq);
        return {2'(dest), 46'h0, 8'(src), 8'(seq)};
    endfunction

    function automatic int src_of(input int k);
        case (k % 3)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    int          sent [4];
    int          n_out [4];
    int          got;
    int          cyc;
    int          first;
    int          last;
    logic [3:0]  hs_in;
    logic [3:0]  hs_vec;
    logic        hs_out;
    logic [63:0] dout;
    logic [63:0] seen;

    initial begin
        rst = 1'b1;
        bus4.data_cpu_to_noc_vld = '0;
        bus4.data_cpu_to_noc     = '0;
        bus4.data_noc_to_cpu_rdy = '0;
        bus3.data_cpu_to_noc_vld = '0;
        bus3.data_cpu_to_noc     = '0;
        bus3.data_noc_to_cpu_rdy = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_rdy4", 64'(bus4.data_cpu_to_noc_rdy), 64'hF);
        check("rst_vld4", 64'(bus4.data_noc_to_cpu_vld), 64'h0);
        for (int j = 0; j < 4; j++) check("rst_data4", bus4.data_noc_to_cpu[j], 64'h0);
        check("rst_rdy3", 64'(bus3.data_cpu_to_noc_rdy), 64'h7);
        check("rst_vld3", 64'(bus3.data_noc_to_cpu_vld), 64'h0);

        // Single word cpu0 -> out2
        bus4.data_cpu_to_noc_vld = 4'b0001;
        bus4.data_cpu_to_noc[0]  = 64'h8000_0000_0000_00AB;
        tick();
        bus4.data_cpu_to_noc_vld = '0;
        check("single_not_yet", 64'(bus4.data_noc_to_cpu_vld), 64'h0);
        tick();
        check("single_vld", 64'(bus4.data_noc_to_cpu_vld), 64'b0100);
        check("single_data", bus4.data_noc_to_cpu[2], 64'h8000_0000_0000_00AB);
        bus4.data_noc_to_cpu_rdy = 4'b0100;
        tick();
        bus4.data_noc_to_cpu_rdy = '0;
        check("single_popped", 64'(bus4.data_noc_to_cpu_vld), 64'h0);

        // Round-robin: inputs 0,1,3 stream 8 words each to output 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) sent[i] = 0;
        bus4.data_noc_to_cpu_rdy = 4'b0100;
        got = 0;
        cyc = 0;
        first = 0;
        last = 0;
        while (got < 24 && cyc < 200) begin
            for (int i = 0; i < 4; i++) begin
                if (i != 2 && sent[i] < 8) begin
                    bus4.data_cpu_to_noc_vld[i] = 1'b1;
                    bus4.data_cpu_to_noc[i]     = mkword(2, i, sent[i]);
                end else begin
                    bus4.data_cpu_to_noc_vld[i] = 1'b0;
                end
            end
            hs_in  = bus4.data_cpu_to_noc_vld & bus4.data_cpu_to_noc_rdy;
            hs_out = bus4.data_noc_to_cpu_vld[2] & bus4.data_noc_to_cpu_rdy[2];
            dout   = bus4.data_noc_to_cpu[2];
            tick();
            cyc++;
            for (int i = 0; i < 4; i++) if (hs_in[i]) sent[i]++;
            if (hs_out) begin
                check("rr_word", dout, mkword(2, src_of(got), got / 3));
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
        end
        bus4.data_cpu_to_noc_vld = '0;
        check("rr_count", 64'(got), 64'd24);
        check("rr_rate", 64'(last - first), 64'd23);
        check("rr_other_idle", 64'(bus4.data_noc_to_cpu_vld & 4'b1011), 64'h0);
`ifdef NOC_STATS_EN
        check("rr_rx_cnt2", 64'(rx4[2]), 64'd24);
        check("rr_rx_cnt0", 64'(rx4[0]), 64'd0);
`endif

        // Bad destination on the 3-port instance
        bus3.data_noc_to_cpu_rdy = 3'b111;
        bus3.data_cpu_to_noc_vld = 3'b011;
        bus3.data_cpu_to_noc[0]  = mkword(3, 0, 1);
        bus3.data_cpu_to_noc[1]  = mkword(0, 1, 2);
        check("bad_rdy_pre", 64'(bus3.data_cpu_to_noc_rdy), 64'h7);
        tick();
        bus3.data_cpu_to_noc_vld = '0;
        for (int p = 0; p < 3; p++) n_out[p] = 0;
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            hs_vec = {1'b0, bus3.data_noc_to_cpu_vld & bus3.data_noc_to_cpu_rdy};
            if (hs_vec[0]) seen = bus3.data_noc_to_cpu[0];
            tick();
            for (int p = 0; p < 3; p++) if (hs_vec[p]) n_out[p]++;
        end
        check("bad_out0_cnt", 64'(n_out[0]), 64'd1);
        check("bad_out0_data", seen, mkword(0, 1, 2));
        check("bad_out1_cnt", 64'(n_out[1]), 64'd0);
        check("bad_out2_cnt", 64'(n_out[2]), 64'd0);
        check("bad_rdy_post", 64'(bus3.data_cpu_to_noc_rdy), 64'h7);
`ifdef NOC_STATS_EN
        check("bad_drop_cnt", 64'(drop3), 64'd1);
        check("bad_rx_cnt0", 64'(rx3[0]), 64'd1);
`endif

        // Back-pressure: out2 stalled, cpu0 offers 6 words
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus4.data_noc_to_cpu_rdy = '0;
        sent[0] = 0;
        for (int c = 0; c < 10; c++) begin
            bus4.data_cpu_to_noc_vld[0] = (sent[0] < 6);
            bus4.data_cpu_to_noc[0]     = mkword(2, 0, sent[0]);
            hs_in = bus4.data_cpu_to_noc_vld & bus4.data_cpu_to_noc_rdy;
            tick();
            if (hs_in[0]) sent[0]++;
        end
        bus4.data_cpu_to_noc_vld = '0;
        check("bp_accepted", 64'(sent[0]), 64'd6);
        check("bp_rdy0_low", 64'(bus4.data_cpu_to_noc_rdy[0]), 64'd0);
        check("bp_vld2", 64'(bus4.data_noc_to_cpu_vld), 64'b0100);
        check("bp_head", bus4.data_noc_to_cpu[2], mkword(2, 0, 0));
        bus4.data_noc_to_cpu_rdy = 4'b0100;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 40) begin
            hs_out = bus4.data_noc_to_cpu_vld[2] & bus4.data_noc_to_cpu_rdy[2];
            dout   = bus4.data_noc_to_cpu[2];
            tick();
            cyc++;
            if (hs_out) begin
                check("bp_word", dout, mkword(2, 0, got));
                got++;
            end
        end
        check("bp_count", 64'(got), 64'd6);
        tick();
        check("bp_drained", 64'(bus4.data_noc_to_cpu_vld), 64'h0);
        check("bp_rdy0_back", 64'(bus4.data_cpu_to_noc_rdy[0]), 64'd1);

        // Reset while backlogged
        bus4.data_noc_to_cpu_rdy = '0;
        sent[0] = 0;
        for (int c = 0; c < 10; c++) begin
            bus4.data_cpu_to_noc_vld[0] = (sent[0] < 6);
            bus4.data_cpu_to_noc[0]     = mkword(2, 0, sent[0] + 16);
            hs_in = bus4.data_cpu_to_noc_vld & bus4.data_cpu_to_noc_rdy;
            tick();
            if (hs_in[0]) sent[0]++;
        end
        bus4.data_cpu_to_noc_vld = '0;
        check("mr_backlog_rdy0", 64'(bus4.data_cpu_to_noc_rdy[0]), 64'd0);
        rst = 1'b1;
        #1;
        check("mr_vld", 64'(bus4.data_noc_to_cpu_vld), 64'h0);
        check("mr_rdy", 64'(bus4.data_cpu_to_noc_rdy), 64'hF);
        check("mr_data2", bus4.data_noc_to_cpu[2], 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus4.data_noc_to_cpu_rdy = 4'hF;
        bus4.data_cpu_to_noc_vld = 4'b0100;
        bus4.data_cpu_to_noc[2]  = mkword(1, 2, 8'h5A);
        tick();
        bus4.data_cpu_to_noc_vld = '0;
        for (int p = 0; p < 4; p++) n_out[p] = 0;
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            hs_vec = bus4.data_noc_to_cpu_vld & bus4.data_noc_to_cpu_rdy;
            if (hs_vec[1]) seen = bus4.data_noc_to_cpu[1];
            tick();
            for (int p = 0; p < 4; p++) if (hs_vec[p]) n_out[p]++;
        end
        check("mr_out1_cnt", 64'(n_out[1]), 64'd1);
        check("mr_out1_data", seen, mkword(1, 2, 8'h5A));
        check("mr_out2_cnt", 64'(n_out[2]), 64'd0);
        check("mr_out0_cnt", 64'(n_out[0] + n_out[3]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
